turn_ctrl: RTL and testbench
============================

# turn_ctrl

Game-turn sequencer for the connect-four datapath. Owns whose turn it is and, in order, drives the column-drop datapath, the win checker and the minimax AI engine through request/acknowledge handshakes. Counts moves and declares win or draw. Sits between the debounced button/switch front end and the grid/column-count datapath.

## Interface
- `AI_TIMEOUT`, 1048576: maximum number of cycles spent in AI_WAIT before the fallback column is used. Used only when the timeout feature is compiled in.
- `MAX_MOVES`, 42: number of drops that fills the board; reaching it without a win is a draw.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `vs_ai`  in  1  1 = player 2 is the AI; sampled only in TURN.
- `human_go`  in  1  one-cycle pulse requesting a drop in `human_col`.
- `human_col`  in  3  requested column, 0..6.
- `col_full`  in  7  bit i = column i holds 6 pieces.
- `new_game`  in  1  pulse; restarts the game from OVER only.
- `drop_req`  out  1  drop request; held until acknowledged.
- `drop_col`  out  3  column of the pending drop.
- `drop_player`  out  1  owner of the pending drop.
- `drop_ack`  in  1  drop performed; valid only while `drop_req`=1.
- `chk_start`  out  1  one-cycle pulse that starts the win check.
- `chk_done`  in  1  win check finished, one-cycle pulse.
- `chk_win`  in  1  win result, valid with `chk_done`.
- `ai_start`  out  1  one-cycle pulse that starts a minimax search.
- `ai_done`  in  1  AI result valid, one-cycle pulse.
- `ai_col`  in  3  AI chosen column, valid with `ai_done`.
- `player`  out  1  side to move: 0 = player 1, 1 = player 2 or AI.
- `term`  out  1  game over.
- `winner`  out  2  00 none or draw, 01 player 1, 10 player 2.
- `moves`  out  6  completed drops, 0..42.
- `busy`  out  1  high in every state except HUMAN and OVER.

## Operation
- **States:** TURN, HUMAN, AI_START, AI_WAIT, DROP, CHK_START, CHK_WAIT, OVER. All outputs are registered.
- **Reset values:** state=TURN, `player`=0, `term`=0, `winner`=00, `moves`=0, `drop_req`=0, `drop_col`=0, `drop_player`=0, `chk_start`=0, `ai_start`=0, `busy`=1.
- **TURN:**
  - `vs_ai`=1 and `player`=1: go to AI_START.
  - Otherwise: go to HUMAN.
- **HUMAN:**
  - `human_go` with `human_col`≤6 and `col_full[human_col]`=0: latch the column, go to DROP.
  - Illegal or full column: ignore the pulse and stay in HUMAN.
- **AI_START:** pulse `ai_start` for one cycle, clear the timeout counter, go to AI_WAIT.
- **AI_WAIT:**
  - On `ai_done`, a legal `ai_col` is latched.
  - If `ai_col`>6 or that column is full, latch the fallback column instead: the lowest-index column with `col_full`=0.
  - Then go to DROP.
  - `human_go` is ignored in this state.
- **DROP:**
  - `drop_req`=1 with `drop_col` and `drop_player`=`player` held stable.
  - `drop_ack` while `drop_req`=1: go to CHK_START.
- **CHK_START:** pulse `chk_start` for one cycle, go to CHK_WAIT.
- **CHK_WAIT on `chk_done`:**
  - `moves` increments (saturates at 42).
  - If `chk_win`=1: `winner`=`player`+1, `term`=1, go to OVER.
  - Else if the new count equals `MAX_MOVES`: `winner`=00, `term`=1, go to OVER.
  - Else: toggle `player`, go to TURN.
- **OVER:**
  - All requests are ignored.
  - `new_game`: restore the reset values of every register except the asynchronous path, go to TURN.
- **Simultaneous events:** `new_game` outside OVER is ignored. A `drop_ack` while `drop_req`=0 is ignored. A `chk_done` outside CHK_WAIT and an `ai_done` outside AI_WAIT are ignored.
- **Reset mid-operation:** any outstanding handshake is abandoned immediately. The datapath shares `rst`, so no cleanup sequence is needed.

## Timing
- `human_go` at cycle N (in HUMAN) gives `drop_req`=1 at N+1.
- `drop_ack` at cycle M gives `drop_req`=0 and `chk_start`=1 at M+1, and `chk_start`=0 at M+2.
- `chk_done` at cycle K gives the `term`/`winner` update or the `player` toggle at K+1. The next `ai_start` or HUMAN entry follows at K+2.
- From TURN, `ai_start` is high one cycle later. `ai_done` at cycle A gives `drop_req`=1 at A+1.
- The minimum full human turn is 5 cycles plus the handshake latencies.

## Configuration
- **`TURN_CTRL_AI_TIMEOUT_EN` defined:**
  - The timeout counter runs in AI_WAIT.
  - When it reaches `AI_TIMEOUT` cycles without `ai_done`, the fallback column is latched and the FSM goes to DROP.
  - A later `ai_done` is ignored.
- **Undefined:** no counter is built and AI_WAIT waits indefinitely for `ai_done`.

## Test plan
- Reset, `vs_ai`=0, `human_go` col 3 → `drop_req`=1, `drop_col`=3, `drop_player`=0 next cycle. After ack and `chk_done`/`chk_win`=0: `player`=1, `moves`=1.
- `col_full`=7'b0001000, `human_go` col 3, then col 7 → both ignored; state stays HUMAN, `drop_req`=0.
- `vs_ai`=1, after player 1's move → `ai_start` pulses once. `ai_done` with `ai_col`=5 while col 5 is full and `col_full`=7'b0100001 → `drop_col`=1.
- `chk_win`=1 on player 2's drop → `term`=1, `winner`=10. A `human_go` then gives no `drop_req`. `new_game` gives `moves`=0, `player`=0, `term`=0.
- 42 drops with no win → after the 42nd `chk_done`: `term`=1, `winner`=00, `moves`=42.
- `rst` asserted while `drop_req`=1 → `drop_req`=0 immediately, state TURN. With `TURN_CTRL_AI_TIMEOUT_EN` and `AI_TIMEOUT`=16, no `ai_done` → `drop_req` rises 17 cycles after `ai_start`.

Source files
------------

// File: rtl/turn_ctrl.sv
// Connect-four turn sequencer: sequences human/AI column choice, drop, and win check.
// Optional AI watchdog is compiled in with `define TURN_CTRL_AI_TIMEOUT_EN.
module turn_ctrl #(
  parameter int unsigned AI_TIMEOUT = 1048576,
  parameter int unsigned MAX_MOVES  = 42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vs_ai,
  input  logic       human_go,
  input  logic [2:0] human_col,
  input  logic [6:0] col_full,
  input  logic       new_game,
  output logic       drop_req,
  output logic [2:0] drop_col,
  output logic       drop_player,
  input  logic       drop_ack,
  output logic       chk_start,
  input  logic       chk_done,
  input  logic       chk_win,
  output logic       ai_start,
  input  logic       ai_done,
  input  logic [2:0] ai_col,
  output logic       player,
  output logic       term,
  output logic [1:0] winner,
  output logic [5:0] moves,
  output logic       busy
);

  localparam int unsigned COL_W  = 3;
  localparam int unsigned NCOL   = 7;
  localparam int unsigned MOVE_W = 6;

  if (AI_TIMEOUT == 0) begin : g_bad_timeout
    $error("turn_ctrl: AI_TIMEOUT must be nonzero");
  end

  typedef enum logic [2:0] {
    S_TURN,
    S_HUMAN,
    S_AI_START,
    S_AI_WAIT,
    S_DROP,
    S_CHK_START,
    S_CHK_WAIT,
    S_OVER
  } state_e;

  state_e             state_q, state_d;
  logic               player_q, player_d;
  logic               term_q, term_d;
  logic [1:0]         winner_q, winner_d;
  logic [MOVE_W-1:0]  moves_q, moves_d;
  logic               drop_req_q, drop_req_d;
  logic [COL_W-1:0]   drop_col_q, drop_col_d;
  logic               drop_player_q, drop_player_d;
  logic               chk_start_q, chk_start_d;
  logic               ai_start_q, ai_start_d;
  logic               busy_q, busy_d;

  // Column 7 does not exist, so it reads as permanently full.
  logic [NCOL:0]      full_ext;
  logic [COL_W-1:0]   fallback_col;
  logic               ai_tmo_c;

  assign full_ext = {1'b1, col_full};

  // Lowest-index column that still has room.
  always_comb begin
    fallback_col = '0;
    for (int i = int'(NCOL) - 1; i >= 0; i--) begin
      if (!col_full[i]) fallback_col = COL_W'(i);
    end
  end

`ifdef TURN_CTRL_AI_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(AI_TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign ai_tmo_c = (state_q == S_AI_WAIT) && (tmo_cnt_q == TMO_W'(AI_TIMEOUT - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == S_AI_START)     tmo_cnt_d = '0;
    else if (state_q == S_AI_WAIT) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign ai_tmo_c = 1'b0;
`endif

  // Next state and registered-output next values.
  always_comb begin
    state_d       = state_q;
    player_d      = player_q;
    term_d        = term_q;
    winner_d      = winner_q;
    moves_d       = moves_q;
    drop_col_d    = drop_col_q;
    drop_player_d = drop_player_q;

    case (state_q)
      S_TURN: begin
        state_d = (vs_ai && player_q) ? S_AI_START : S_HUMAN;
      end
      S_HUMAN: begin
        if (human_go && !full_ext[human_col]) begin
          drop_col_d    = human_col;
          drop_player_d = player_q;
          state_d       = S_DROP;
        end
      end
      S_AI_START: begin
        state_d = S_AI_WAIT;
      end
      S_AI_WAIT: begin
        if (ai_done) begin
          drop_col_d    = full_ext[ai_col] ? fallback_col : ai_col;
          drop_player_d = player_q;
          state_d       = S_DROP;
        end else if (ai_tmo_c) begin
          drop_col_d    = fallback_col;
          drop_player_d = player_q;
          state_d       = S_DROP;
        end
      end
      S_DROP: begin
        if (drop_ack && drop_req_q) state_d = S_CHK_START;
      end
      S_CHK_START: begin
        state_d = S_CHK_WAIT;
      end
      S_CHK_WAIT: begin
        if (chk_done) begin
          moves_d = (moves_q >= MOVE_W'(MAX_MOVES)) ? moves_q : moves_q + MOVE_W'(1);
          if (chk_win) begin
            winner_d = {player_q, ~player_q};
            term_d   = 1'b1;
            state_d  = S_OVER;
          end else if (moves_d == MOVE_W'(MAX_MOVES)) begin
            winner_d = 2'b00;
            term_d   = 1'b1;
            state_d  = S_OVER;
          end else begin
            player_d = ~player_q;
            state_d  = S_TURN;
          end
        end
      end
      S_OVER: begin
        if (new_game) begin
          state_d       = S_TURN;
          player_d      = 1'b0;
          term_d        = 1'b0;
          winner_d      = 2'b00;
          moves_d       = '0;
          drop_col_d    = '0;
          drop_player_d = 1'b0;
        end
      end
      default: begin
        state_d = S_TURN;
      end
    endcase

    // Handshake strobes follow the state being entered so they align with it.
    drop_req_d  = (state_d == S_DROP);
    chk_start_d = (state_d == S_CHK_START);
    ai_start_d  = (state_d == S_AI_START);
    busy_d      = !((state_d == S_HUMAN) || (state_d == S_OVER));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_TURN;
      player_q      <= 1'b0;
      term_q        <= 1'b0;
      winner_q      <= 2'b00;
      moves_q       <= '0;
      drop_req_q    <= 1'b0;
      drop_col_q    <= '0;
      drop_player_q <= 1'b0;
      chk_start_q   <= 1'b0;
      ai_start_q    <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      player_q      <= player_d;
      term_q        <= term_d;
      winner_q      <= winner_d;
      moves_q       <= moves_d;
      drop_req_q    <= drop_req_d;
      drop_col_q    <= drop_col_d;
      drop_player_q <= drop_player_d;
      chk_start_q   <= chk_start_d;
      ai_start_q    <= ai_start_d;
      busy_q        <= busy_d;
    end
  end

  assign player      = player_q;
  assign term        = term_q;
  assign winner      = winner_q;
  assign moves       = moves_q;
  assign drop_req    = drop_req_q;
  assign drop_col    = drop_col_q;
  assign drop_player = drop_player_q;
  assign chk_start   = chk_start_q;
  assign ai_start    = ai_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_turn_ctrl.sv
// Directed self-checking bench for turn_ctrl.
module tb_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs_ai;
  logic       human_go;
  logic [2:0] human_col;
  logic [6:0] col_full;
  logic       new_game;
  logic       drop_req;
  logic [2:0] drop_col;
  logic       drop_player;
  logic       drop_ack;
  logic       chk_start;
  logic       chk_done;
  logic       chk_win;
  logic       ai_start;
  logic       ai_done;
  logic [2:0] ai_col;
  logic       player;
  logic       term;
  logic [1:0] winner;
  logic [5:0] moves;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  turn_ctrl #(.AI_TIMEOUT(16), .MAX_MOVES(42)) dut (
    .clk(clk), .rst(rst), .vs_ai(vs_ai), .human_go(human_go), .human_col(human_col),
    .col_full(col_full), .new_game(new_game), .drop_req(drop_req), .drop_col(drop_col),
    .drop_player(drop_player), .drop_ack(drop_ack), .chk_start(chk_start),
    .chk_done(chk_done), .chk_win(chk_win), .ai_start(ai_start), .ai_done(ai_done),
    .ai_col(ai_col), .player(player), .term(term), .winner(winner), .moves(moves),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wait_ready: busy=%b after %0d cycles, want 0", busy, n); end
  endtask

  task automatic do_move(input logic [2:0] col, input logic win);
    wait_ready();
    human_col = col; human_go = 1'b1; tick(); human_go = 1'b0;
    drop_ack = 1'b1; tick(); drop_ack = 1'b0;
    tick();
    chk_done = 1'b1; chk_win = win; tick(); chk_done = 1'b0; chk_win = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vs_ai = 1'b0; human_go = 1'b0; human_col = 3'd0; col_full = 7'd0;
    new_game = 1'b0; drop_ack = 1'b0; chk_done = 1'b0; chk_win = 1'b0;
    ai_done = 1'b0; ai_col = 3'd0;
    tick(); tick();
    checks++; if (player !== 1'b0)   begin errors++; $display("FAIL rst_player: got %b want 0", player); end
    checks++; if (term !== 1'b0)     begin errors++; $display("FAIL rst_term: got %b want 0", term); end
    checks++; if (winner !== 2'b00)  begin errors++; $display("FAIL rst_winner: got %b want 00", winner); end
    checks++; if (moves !== 6'd0)    begin errors++; $display("FAIL rst_moves: got %0d want 0", moves); end
    checks++; if (drop_req !== 1'b0) begin errors++; $display("FAIL rst_drop_req: got %b want 0", drop_req); end
    checks++; if (chk_start !== 1'b0 || ai_start !== 1'b0) begin errors++; $display("FAIL rst_pulses: chk_start=%b ai_start=%b want 0 0", chk_start, ai_start); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL rst_busy: got %b want 1", busy); end
    rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_to_human: busy=%b want 0", busy); end
  endtask

  task automatic test_human_move();
    human_col = 3'd3; human_go = 1'b1; tick(); human_go = 1'b0;
    checks++; if (drop_req !== 1'b1)    begin errors++; $display("FAIL hm_drop_req: got %b want 1", drop_req); end
    checks++; if (drop_col !== 3'd3)    begin errors++; $display("FAIL hm_drop_col: got %0d want 3", drop_col); end
    checks++; if (drop_player !== 1'b0) begin errors++; $display("FAIL hm_drop_player: got %b want 0", drop_player); end
    tick();
    checks++; if (drop_req !== 1'b1)    begin errors++; $display("FAIL hm_drop_hold: got %b want 1", drop_req); end
    drop_ack = 1'b1; tick(); drop_ack = 1'b0;
    checks++; if (drop_req !== 1'b0 || chk_start !== 1'b1) begin errors++; $display("FAIL hm_ack: drop_req=%b chk_start=%b want 0 1", drop_req, chk_start); end
    tick();
    checks++; if (chk_start !== 1'b0)   begin errors++; $display("FAIL hm_chk_pulse: got %b want 0", chk_start); end
    chk_done = 1'b1; tick(); chk_done = 1'b0;
    checks++; if (player !== 1'b1 || moves !== 6'd1 || term !== 1'b0) begin errors++; $display("FAIL hm_result: player=%b moves=%0d term=%b want 1 1 0", player, moves, term); end
    tick();
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL hm_next_human: busy=%b want 0", busy); end
  endtask

  task automatic test_illegal();
    col_full = 7'b0001000;
    human_col = 3'd3; human_go = 1'b1; tick();
    checks++; if (drop_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL il_full_col: drop_req=%b busy=%b want 0 0", drop_req, busy); end
    human_col = 3'd7; tick(); human_go = 1'b0;
    checks++; if (drop_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL il_col7: drop_req=%b busy=%b want 0 0", drop_req, busy); end
    col_full = 7'd0;
    drop_ack = 1'b1; chk_done = 1'b1; tick(); drop_ack = 1'b0; chk_done = 1'b0;
    checks++; if (chk_start !== 1'b0 || moves !== 6'd1) begin errors++; $display("FAIL il_spurious: chk_start=%b moves=%0d want 0 1", chk_start, moves); end
    do_move(3'd0, 1'b0);
    checks++; if (player !== 1'b0 || moves !== 6'd2) begin errors++; $display("FAIL il_p2_move: player=%b moves=%0d want 0 2", player, moves); end
  endtask

  task automatic test_ai_fallback_win();
    vs_ai = 1'b1;
    do_move(3'd2, 1'b0);
    checks++; if (player !== 1'b1 || moves !== 6'd3) begin errors++; $display("FAIL ai_pre: player=%b moves=%0d want 1 3", player, moves); end
    tick();
    checks++; if (ai_start !== 1'b1) begin errors++; $display("FAIL ai_start_hi: got %b want 1", ai_start); end
    tick();
    checks++; if (ai_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ai_start_lo: ai_start=%b busy=%b want 0 1", ai_start, busy); end
    human_col = 3'd4; human_go = 1'b1; new_game = 1'b1; tick(); human_go = 1'b0; new_game = 1'b0;
    checks++; if (drop_req !== 1'b0 || moves !== 6'd3) begin errors++; $display("FAIL ai_ignore_go: drop_req=%b moves=%0d want 0 3", drop_req, moves); end
    col_full = 7'b0100001; ai_col = 3'd5; ai_done = 1'b1; tick(); ai_done = 1'b0;
    checks++; if (drop_req !== 1'b1 || drop_col !== 3'd1 || drop_player !== 1'b1) begin errors++; $display("FAIL ai_fallback: req=%b col=%0d plr=%b want 1 1 1", drop_req, drop_col, drop_player); end
    col_full = 7'd0;
    drop_ack = 1'b1; tick(); drop_ack = 1'b0;
    tick();
    chk_done = 1'b1; chk_win = 1'b1; tick(); chk_done = 1'b0; chk_win = 1'b0;
    checks++; if (term !== 1'b1 || winner !== 2'b10 || moves !== 6'd4) begin errors++; $display("FAIL ai_win: term=%b winner=%b moves=%0d want 1 10 4", term, winner, moves); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL over_busy: got %b want 0", busy); end
    human_col = 3'd0; human_go = 1'b1; tick(); human_go = 1'b0;
    checks++; if (drop_req !== 1'b0 || term !== 1'b1) begin errors++; $display("FAIL over_ignore: drop_req=%b term=%b want 0 1", drop_req, term); end
    new_game = 1'b1; tick(); new_game = 1'b0;
    checks++; if (moves !== 6'd0 || player !== 1'b0 || term !== 1'b0 || winner !== 2'b00) begin errors++; $display("FAIL new_game: moves=%0d player=%b term=%b winner=%b want 0 0 0 00", moves, player, term, winner); end
  endtask

  task automatic test_back_to_back();
    do_move(3'd6, 1'b0);
    tick(); tick();
    ai_col = 3'd4; ai_done = 1'b1; tick(); ai_done = 1'b0;
    checks++; if (drop_req !== 1'b1 || drop_col !== 3'd4 || drop_player !== 1'b1) begin errors++; $display("FAIL ai_legal: req=%b col=%0d plr=%b want 1 4 1", drop_req, drop_col, drop_player); end
    drop_ack = 1'b1; tick(); drop_ack = 1'b0; tick();
    chk_done = 1'b1; tick(); chk_done = 1'b0;
    checks++; if (player !== 1'b0 || moves !== 6'd2) begin errors++; $display("FAIL ai_legal_res: player=%b moves=%0d want 0 2", player, moves); end
    do_move(3'd1, 1'b0);
    tick(); tick();
    ai_col = 3'd7; ai_done = 1'b1; tick(); ai_done = 1'b0;
    checks++; if (drop_col !== 3'd0 || drop_req !== 1'b1) begin errors++; $display("FAIL ai_col7: col=%0d req=%b want 0 1", drop_col, drop_req); end
    drop_ack = 1'b1; tick(); drop_ack = 1'b0; tick();
    chk_done = 1'b1; tick(); chk_done = 1'b0;
    checks++; if (player !== 1'b0 || moves !== 6'd4) begin errors++; $display("FAIL b2b_res: player=%b moves=%0d want 0 4", player, moves); end
    vs_ai = 1'b0;
  endtask

  task automatic test_draw();
    for (int i = 0; i < 38; i++) begin
      do_move(3'(i % 7), 1'b0);
      if (i == 36) begin
        checks++; if (term !== 1'b0 || moves !== 6'd41) begin errors++; $display("FAIL draw_41: term=%b moves=%0d want 0 41", term, moves); end
      end
    end
    checks++; if (term !== 1'b1 || winner !== 2'b00 || moves !== 6'd42) begin errors++; $display("FAIL draw_42: term=%b winner=%b moves=%0d want 1 00 42", term, winner, moves); end
    new_game = 1'b1; tick(); new_game = 1'b0;
    checks++; if (moves !== 6'd0 || term !== 1'b0) begin errors++; $display("FAIL draw_restart: moves=%0d term=%b want 0 0", moves, term); end
  endtask

  task automatic test_reset_mid();
    wait_ready();
    human_col = 3'd5; human_go = 1'b1; tick(); human_go = 1'b0;
    checks++; if (drop_req !== 1'b1) begin errors++; $display("FAIL mid_pre: drop_req=%b want 1", drop_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (drop_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL mid_async: drop_req=%b busy=%b want 0 1", drop_req, busy); end
    @(posedge clk); #1 rst = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || drop_req !== 1'b0) begin errors++; $display("FAIL mid_resume: busy=%b drop_req=%b want 0 0", busy, drop_req); end
  endtask

`ifdef TURN_CTRL_AI_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    vs_ai = 1'b1;
    do_move(3'd3, 1'b0);
    while (ai_start !== 1'b1 && n < 10) begin tick(); n++; end
    n = 0;
    while (drop_req !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (n != 17 || drop_col !== 3'd0) begin errors++; $display("FAIL ai_timeout: cycles=%0d col=%0d want 17 0", n, drop_col); end
    drop_ack = 1'b1; tick(); drop_ack = 1'b0; tick();
    chk_done = 1'b1; tick(); chk_done = 1'b0;
    vs_ai = 1'b0;
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_human_move();
    test_illegal();
    test_ai_fallback_win();
    test_back_to_back();
    test_draw();
    test_reset_mid();
`ifdef TURN_CTRL_AI_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
